// File: rtl/sma_crossover_signal.sv
// Moving-average crossover detector: compares fast/slow SMA streams with hysteresis,
// issues buy/sell signals over valid/ready, and tracks the resulting position.
module sma_crossover_signal #(
  parameter int DATA_W   = 8,
  parameter int WARMUP   = 4,
  parameter int HYST     = 2,
  parameter int COOLDOWN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fast_in,
  input  logic              fast_valid,
  input  logic [DATA_W-1:0] slow_in,
  input  logic              slow_valid,
  input  logic              sig_ready,
  output logic              sig_valid,
  output logic              sig_dir,
  output logic [DATA_W-1:0] sig_price,
  output logic [1:0]        position,
  output logic              warm,
  output logic [7:0]        drop_cnt
);

  localparam int WW = $clog2(WARMUP + 1) + 1;
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [WW-1:0]            WARMUP_L = WW'(WARMUP);
  localparam logic [CW-1:0]            COOL_L   = CW'(COOLDOWN);
  localparam logic signed [DATA_W:0]   HYST_POS = (DATA_W + 1)'(HYST);
  localparam logic signed [DATA_W:0]   HYST_NEG = -HYST_POS;
  localparam logic signed [DATA_W:0]   ZERO     = '0;

  typedef enum logic [1:0] {
    ST_WARMUP,
    ST_FLAT,
    ST_LONG,
    ST_SHORT
  } state_t;

  state_t state, state_next;

  logic [WW-1:0] warm_cnt, warm_cnt_next;
  logic [CW-1:0] cool_cnt;

  logic                 strobe;
  logic                 accept;
  logic                 eligible;
  logic signed [DATA_W:0] diff;
  logic                 buy_cond;
  logic                 sell_cond;
  logic                 trig_buy;
  logic                 trig_sell;

  // Zero-extending both operands keeps the subtraction exact in DATA_W+1 bits.
  assign strobe    = fast_valid && slow_valid;
  assign accept    = sig_valid && sig_ready;
  assign eligible  = strobe && !sig_valid && (cool_cnt == '0);
  assign diff      = $signed({1'b0, fast_in}) - $signed({1'b0, slow_in});
  assign buy_cond  = (diff > ZERO) && (diff >= HYST_POS);
  assign sell_cond = (diff < ZERO) && (diff <= HYST_NEG);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_WARMUP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    warm_cnt_next = warm_cnt;
    trig_buy      = 1'b0;
    trig_sell     = 1'b0;
    case (state)
      ST_WARMUP: begin
        if (strobe) begin
          warm_cnt_next = warm_cnt + 1'b1;
        end
        if (warm_cnt_next >= WARMUP_L) begin
          state_next = ST_FLAT;
        end
      end
      ST_FLAT: begin
        if (eligible && buy_cond) begin
          trig_buy   = 1'b1;
          state_next = ST_LONG;
        end else if (eligible && sell_cond) begin
          trig_sell  = 1'b1;
          state_next = ST_SHORT;
        end
      end
      // Only the opposite crossing matters once a position is held.
      ST_LONG: begin
        if (eligible && sell_cond) begin
          trig_sell  = 1'b1;
          state_next = ST_SHORT;
        end
      end
      ST_SHORT: begin
        if (eligible && buy_cond) begin
          trig_buy   = 1'b1;
          state_next = ST_LONG;
        end
      end
      default: begin
        state_next = ST_WARMUP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warm_cnt  <= '0;
      cool_cnt  <= '0;
      warm      <= 1'b0;
      drop_cnt  <= '0;
      sig_valid <= 1'b0;
      sig_dir   <= 1'b0;
      sig_price <= '0;
      position  <= 2'b00;
    end else begin
      warm_cnt <= warm_cnt_next;
      warm     <= (state_next != ST_WARMUP);

      if (strobe && sig_valid && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      if (accept) begin
        sig_valid <= 1'b0;
        cool_cnt  <= COOL_L;
      end else if (cool_cnt != '0) begin
        cool_cnt <= cool_cnt - 1'b1;
      end

      // A trigger needs sig_valid=0, so it never collides with an accept.
      if (trig_buy || trig_sell) begin
        sig_valid <= 1'b1;
        sig_dir   <= trig_buy;
        sig_price <= fast_in;
        position  <= trig_buy ? 2'b01 : 2'b10;
      end
    end
  end

endmodule
